cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB result arbiter with per-requester starvation tracking
// Optional feature macro: CDB_STARVE_BOOST_EN (starved requesters override round-robin order).
module cdb_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int STARVE_LIMIT = 7,
    parameter int IDX_W        = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               cdb_stall,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] starve_flag,
    output logic [15:0]        grant_total
);

    // STARVE_LIMIT tops out at 255, so eight bits always hold a wait count.
    localparam int CNT_W = 8;

    logic [IDX_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0][CNT_W-1:0] wait_q, wait_d;
    logic [15:0]                   total_q, total_d;

    logic [NUM_REQ-1:0] starve_w;
    logic [NUM_REQ-1:0] gnt_w;
    logic [IDX_W-1:0]   idx_w;
    logic               found;
    int                 cand;

    // A requester is starved once its wait count has saturated.
    always_comb begin
        starve_w = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starve_w[i] = (wait_q[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    // Same-cycle grant selection: starved override (if enabled), else scan upward from rr_ptr.
    always_comb begin
        gnt_w = '0;
        idx_w = '0;
        found = 1'b0;
        cand  = 0;
        if (reset_n && !flush && !cdb_stall) begin
`ifdef CDB_STARVE_BOOST_EN
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && starve_w[i]) begin
                    found = 1'b1;
                    idx_w = IDX_W'(i);
                end
            end
`endif
            for (int off = 0; off < NUM_REQ; off++) begin
                cand = (int'(rr_ptr_q) + off) % NUM_REQ;
                if (!found && req[IDX_W'(cand)]) begin
                    found = 1'b1;
                    idx_w = IDX_W'(cand);
                end
            end
            if (found) begin
                gnt_w[idx_w] = 1'b1;
            end
        end
    end

    // Next-state: flush clears everything, a stall freezes everything, otherwise advance.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wait_d   = wait_q;
        total_d  = total_q;
        if (flush) begin
            rr_ptr_d = '0;
            wait_d   = '0;
            total_d  = '0;
        end else if (!cdb_stall) begin
            if (found) begin
                rr_ptr_d = (idx_w == IDX_W'(NUM_REQ - 1)) ? '0 : idx_w + 1'b1;
                total_d  = total_q + 16'd1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i] || gnt_w[i]) begin
                    wait_d[i] = '0;
                end else if (!starve_w[i]) begin
                    wait_d[i] = wait_q[i] + 1'b1;
                end
            end
        end
    end

    // Arbitration state registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            wait_q   <= '0;
            total_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wait_q   <= wait_d;
            total_q  <= total_d;
        end
    end

    assign gnt         = gnt_w;
    assign gnt_valid   = |gnt_w;
    assign gnt_idx     = idx_w;
    assign rr_ptr      = rr_ptr_q;
    assign starve_flag = reset_n ? starve_w : '0;
    assign grant_total = total_q;

endmodule
